// File: rtl/riscv_pkg.sv
// Shared pipeline types: control bundle, result-source encodings, bubble counter helper.
package riscv_pkg;

  localparam int unsigned BUBBLE_W = 16;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } result_src_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    result_src_e result_src;
    logic [3:0]  alu_ctrl;
    logic        alu_src;
    logic        branch;
    logic        jump;
  } ctrl_t;

  // Control word that has no architectural side effect.
  localparam ctrl_t CTRL_NOP = '{
    reg_write:  1'b0,
    mem_write:  1'b0,
    result_src: RES_ALU,
    alu_ctrl:   4'h0,
    alu_src:    1'b0,
    branch:     1'b0,
    jump:       1'b0
  };

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [BUBBLE_W-1:0] sat_inc(input logic [BUBBLE_W-1:0] v);
    return (&v) ? v : v + BUBBLE_W'(1);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute pipeline register bus: decode inputs, write-back port, controls, execute view.
interface id_ex_stage_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 5
) ();
  import riscv_pkg::*;

  // decode slot
  logic                     d_valid;
  logic [DATA_WIDTH-1:0]    d_pc;
  logic [DATA_WIDTH-1:0]    d_pc_plus4;
  logic [DATA_WIDTH-1:0]    d_imm;
  logic [ADDRESS_WIDTH-1:0] d_rs1;
  logic [ADDRESS_WIDTH-1:0] d_rs2;
  logic [ADDRESS_WIDTH-1:0] d_rd;
  logic [DATA_WIDTH-1:0]    d_rd1;
  logic [DATA_WIDTH-1:0]    d_rd2;
  ctrl_t                    d_ctrl;

  // same-cycle register-file write port
  logic                     wb_we;
  logic [ADDRESS_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0]    wb_wd;

  // pipeline control
  logic                     flush;
  logic                     ext_stall;

  // execute view
  logic                     e_valid;
  logic [DATA_WIDTH-1:0]    e_pc;
  logic [DATA_WIDTH-1:0]    e_pc_plus4;
  logic [DATA_WIDTH-1:0]    e_imm;
  logic [ADDRESS_WIDTH-1:0] e_rs1;
  logic [ADDRESS_WIDTH-1:0] e_rs2;
  logic [ADDRESS_WIDTH-1:0] e_rd;
  logic [DATA_WIDTH-1:0]    e_rd1;
  logic [DATA_WIDTH-1:0]    e_rd2;
  ctrl_t                    e_ctrl;
  logic                     load_use_stall;
  logic [BUBBLE_W-1:0]      bubble_count;

  modport master (
    output d_valid, d_pc, d_pc_plus4, d_imm, d_rs1, d_rs2, d_rd, d_rd1, d_rd2, d_ctrl,
    output wb_we, wb_rd, wb_wd, flush, ext_stall,
    input  e_valid, e_pc, e_pc_plus4, e_imm, e_rs1, e_rs2, e_rd, e_rd1, e_rd2, e_ctrl,
    input  load_use_stall, bubble_count
  );

  modport slave (
    input  d_valid, d_pc, d_pc_plus4, d_imm, d_rs1, d_rs2, d_rd, d_rd1, d_rd2, d_ctrl,
    input  wb_we, wb_rd, wb_wd, flush, ext_stall,
    output e_valid, e_pc, e_pc_plus4, e_imm, e_rs1, e_rs2, e_rd, e_rd1, e_rd2, e_ctrl,
    output load_use_stall, bubble_count
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard: instruction in decode reads the register a load in execute has not produced yet.
module hazard_detect
  import riscv_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 5
) (
  input  logic                     d_valid,
  input  logic [ADDRESS_WIDTH-1:0] d_rs1,
  input  logic [ADDRESS_WIDTH-1:0] d_rs2,
  input  logic                     e_valid,
  input  result_src_e              e_result_src,
  input  logic [ADDRESS_WIDTH-1:0] e_rd,
  input  logic                     flush,
  output logic                     load_use_stall
);

  // A flush kills the decode slot, so there is nothing left to protect.
  assign load_use_stall = !flush && d_valid && e_valid &&
                          (e_result_src == RES_LOAD) &&
                          (e_rd != '0) &&
                          ((e_rd == d_rs1) || (e_rd == d_rs2));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass, load-use bubbles, flush and external hold.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 5
) (
  input  logic         clk,
  input  logic         reset,
  id_ex_stage_if.slave bus
);

  logic                     e_valid_q,      e_valid_d;
  ctrl_t                    e_ctrl_q,       e_ctrl_d;
  logic [DATA_WIDTH-1:0]    e_pc_q,         e_pc_d;
  logic [DATA_WIDTH-1:0]    e_pc_plus4_q,   e_pc_plus4_d;
  logic [DATA_WIDTH-1:0]    e_imm_q,        e_imm_d;
  logic [ADDRESS_WIDTH-1:0] e_rs1_q,        e_rs1_d;
  logic [ADDRESS_WIDTH-1:0] e_rs2_q,        e_rs2_d;
  logic [ADDRESS_WIDTH-1:0] e_rd_q,         e_rd_d;
  logic [DATA_WIDTH-1:0]    e_rd1_q,        e_rd1_d;
  logic [DATA_WIDTH-1:0]    e_rd2_q,        e_rd2_d;
  logic [BUBBLE_W-1:0]      bubble_count_q, bubble_count_d;

  logic lu_stall;
  logic wb_live;
  logic byp_d1, byp_d2;
  logic byp_e1, byp_e2;

  hazard_detect #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_hazard_detect (
    .d_valid        (bus.d_valid),
    .d_rs1          (bus.d_rs1),
    .d_rs2          (bus.d_rs2),
    .e_valid        (e_valid_q),
    .e_result_src   (e_ctrl_q.result_src),
    .e_rd           (e_rd_q),
    .flush          (bus.flush),
    .load_use_stall (lu_stall)
  );

  // Write-back matches: against decode sources on capture, against held sources while stalled.
  always_comb begin
    wb_live = bus.wb_we && (bus.wb_rd != '0);
    byp_d1  = wb_live && (bus.wb_rd == bus.d_rs1);
    byp_d2  = wb_live && (bus.wb_rd == bus.d_rs2);
    byp_e1  = wb_live && (bus.wb_rd == e_rs1_q);
    byp_e2  = wb_live && (bus.wb_rd == e_rs2_q);
  end

  // Next-state selection: flush > ext_stall > load-use bubble > capture.
  always_comb begin
    e_valid_d      = e_valid_q;
    e_ctrl_d       = e_ctrl_q;
    e_pc_d         = e_pc_q;
    e_pc_plus4_d   = e_pc_plus4_q;
    e_imm_d        = e_imm_q;
    e_rs1_d        = e_rs1_q;
    e_rs2_d        = e_rs2_q;
    e_rd_d         = e_rd_q;
    e_rd1_d        = e_rd1_q;
    e_rd2_d        = e_rd2_q;
    bubble_count_d = bubble_count_q;

    if (bus.flush) begin
      e_valid_d = 1'b0;
      e_ctrl_d  = CTRL_NOP;
    end else if (bus.ext_stall) begin
      // Held operands would otherwise go stale if their register is written now.
      if (byp_e1) e_rd1_d = bus.wb_wd;
      if (byp_e2) e_rd2_d = bus.wb_wd;
    end else if (lu_stall) begin
      // Data fields are left as they were; only valid/control matter for a bubble.
      e_valid_d      = 1'b0;
      e_ctrl_d       = CTRL_NOP;
      bubble_count_d = sat_inc(bubble_count_q);
    end else begin
      e_valid_d    = bus.d_valid;
      e_ctrl_d     = bus.d_ctrl;
      e_pc_d       = bus.d_pc;
      e_pc_plus4_d = bus.d_pc_plus4;
      e_imm_d      = bus.d_imm;
      e_rs1_d      = bus.d_rs1;
      e_rs2_d      = bus.d_rs2;
      e_rd_d       = bus.d_rd;
      e_rd1_d      = byp_d1 ? bus.wb_wd : bus.d_rd1;
      e_rd2_d      = byp_d2 ? bus.wb_wd : bus.d_rd2;
    end
  end

  // Pipeline register state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_valid_q      <= 1'b0;
      e_ctrl_q       <= CTRL_NOP;
      e_pc_q         <= '0;
      e_pc_plus4_q   <= '0;
      e_imm_q        <= '0;
      e_rs1_q        <= '0;
      e_rs2_q        <= '0;
      e_rd_q         <= '0;
      e_rd1_q        <= '0;
      e_rd2_q        <= '0;
      bubble_count_q <= '0;
    end else begin
      e_valid_q      <= e_valid_d;
      e_ctrl_q       <= e_ctrl_d;
      e_pc_q         <= e_pc_d;
      e_pc_plus4_q   <= e_pc_plus4_d;
      e_imm_q        <= e_imm_d;
      e_rs1_q        <= e_rs1_d;
      e_rs2_q        <= e_rs2_d;
      e_rd_q         <= e_rd_d;
      e_rd1_q        <= e_rd1_d;
      e_rd2_q        <= e_rd2_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign bus.e_valid        = e_valid_q;
  assign bus.e_ctrl         = e_ctrl_q;
  assign bus.e_pc           = e_pc_q;
  assign bus.e_pc_plus4     = e_pc_plus4_q;
  assign bus.e_imm          = e_imm_q;
  assign bus.e_rs1          = e_rs1_q;
  assign bus.e_rs2          = e_rs2_q;
  assign bus.e_rd           = e_rd_q;
  assign bus.e_rd1          = e_rd1_q;
  assign bus.e_rd2          = e_rd2_q;
  assign bus.bubble_count   = bubble_count_q;
  assign bus.load_use_stall = lu_stall;

endmodule
